// File: rtl/mutex_pkg.sv
// Shared types and helpers for the mutex grant server: client state encoding
// and index/counter width sizing.
package mutex_pkg;

    typedef enum logic [1:0] {
        ST_I = 2'b00,
        ST_T = 2'b01,
        ST_C = 2'b10,
        ST_E = 2'b11
    } mstate_t;

    // $clog2 with a floor of 1 bit, so degenerate sizes still yield a usable vector.
    function automatic int clog2_min1(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mutex_grant_server_rr_pick.sv
// Combinational round-robin selector: first asserted candidate at or above ptr,
// wrapping around to index 0.
module mutex_rr_pick
    import mutex_pkg::*;
#(
    parameter int NCLIENT = 4,
    parameter int IW      = clog2_min1(NCLIENT)
) (
    input  logic [NCLIENT-1:0] cand,
    input  logic [IW-1:0]      ptr,
    output logic               win_valid,
    output logic [IW-1:0]      win_idx
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    // Scan from the farthest offset down, so the nearest candidate to ptr is written last.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        sum       = '0;
        idx       = '0;
        for (int k = NCLIENT - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (IW + 1)'(k);
            if (sum >= (IW + 1)'(NCLIENT)) begin
                sum = sum - (IW + 1)'(NCLIENT);
            end
            idx = sum[IW-1:0];
            if (cand[idx]) begin
                win_valid = 1'b1;
                win_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/mutex_grant_server.sv
// Responder for the I/T/C/E mutual-exclusion protocol: sequences every client,
// admits at most one to its critical section, round-robin, with an optional hold watchdog.
module mutex_grant_server
    import mutex_pkg::*;
#(
    parameter int NCLIENT  = 4,
    parameter int HOLD_MAX = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NCLIENT-1:0]             req,
    input  logic [NCLIENT-1:0]             rel,
    output logic [2*NCLIENT-1:0]           state,
    output logic [NCLIENT-1:0]             grant,
    output logic                           x,
    output logic [clog2_min1(NCLIENT)-1:0] owner,
    output logic                           owner_valid,
    output logic                           timeout_pulse,
    output logic                           proto_err
);

    localparam int IW = clog2_min1(NCLIENT);
    localparam int HW = clog2_min1(HOLD_MAX + 1);

    mstate_t           state_q [NCLIENT];
    mstate_t           state_d [NCLIENT];
    logic              x_q, x_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
    logic              timeout_pulse_q, timeout_pulse_d;
    logic              proto_err_q, proto_err_d;

    logic [NCLIENT-1:0] cand;
    logic [NCLIENT-1:0] busy;
    logic               win_valid;
    logic [IW-1:0]      win_idx;

    always_comb begin
        cand = '0;
        for (int i = 0; i < NCLIENT; i++) begin
            cand[i] = (state_q[i] == ST_T);
        end
    end

    mutex_rr_pick #(
        .NCLIENT(NCLIENT),
        .IW     (IW)
    ) u_rr_pick (
        .cand     (cand),
        .ptr      (rr_ptr_q),
        .win_valid(win_valid),
        .win_idx  (win_idx)
    );

    // A grant needs x_q=1 and an exit needs x_q=0, so both never fire in one cycle.
    always_comb begin
        state_d         = state_q;
        x_d             = x_q;
        rr_ptr_d        = rr_ptr_q;
        hold_cnt_d      = hold_cnt_q;
        timeout_pulse_d = 1'b0;
        proto_err_d     = proto_err_q;
        for (int i = 0; i < NCLIENT; i++) begin
            if (rel[i] && (state_q[i] != ST_C)) begin
                proto_err_d = 1'b1;
            end
            case (state_q[i])
                ST_I: begin
                    if (req[i]) begin
                        state_d[i] = ST_T;
                    end
                end
                ST_T: begin
                    if (x_q && win_valid && (win_idx == IW'(i))) begin
                        state_d[i] = ST_C;
                        x_d        = 1'b0;
                        hold_cnt_d = '0;
                        rr_ptr_d   = (win_idx == IW'(NCLIENT - 1)) ? '0 : win_idx + 1'b1;
                    end
                end
                ST_C: begin
                    // A release wins over a coincident watchdog expiry.
                    if (rel[i]) begin
                        state_d[i] = ST_E;
                    end else if ((HOLD_MAX != 0) && (hold_cnt_q == HW'(HOLD_MAX - 1))) begin
                        state_d[i]      = ST_E;
                        timeout_pulse_d = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                ST_E: begin
                    state_d[i] = ST_I;
                    x_d        = 1'b1;
                end
                default: state_d[i] = ST_I;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCLIENT; i++) begin
                state_q[i] <= ST_I;
            end
            x_q             <= 1'b1;
            rr_ptr_q        <= '0;
            hold_cnt_q      <= '0;
            timeout_pulse_q <= 1'b0;
            proto_err_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            x_q             <= x_d;
            rr_ptr_q        <= rr_ptr_d;
            hold_cnt_q      <= hold_cnt_d;
            timeout_pulse_q <= timeout_pulse_d;
            proto_err_q     <= proto_err_d;
        end
    end

    always_comb begin
        state       = '0;
        grant       = '0;
        busy        = '0;
        owner       = '0;
        owner_valid = 1'b0;
        for (int i = 0; i < NCLIENT; i++) begin
            state[2*i +: 2] = state_q[i];
            grant[i]        = (state_q[i] == ST_C);
            busy[i]         = (state_q[i] == ST_C) || (state_q[i] == ST_E);
            if (busy[i]) begin
                owner       = IW'(i);
                owner_valid = 1'b1;
            end
        end
    end

    assign x             = x_q;
    assign timeout_pulse = timeout_pulse_q;
    assign proto_err     = proto_err_q;

    a_single_owner: assert property (@(posedge clk) disable iff (reset) $onehot0(busy));
    a_sem_owner:    assert property (@(posedge clk) disable iff (reset) (x_q == !owner_valid));
    a_grant_1hot0:  assert property (@(posedge clk) disable iff (reset) $onehot0(grant));

endmodule

// File: tb/tb_mutex_grant_server.sv
// Directed self-checking bench for mutex_grant_server with 4 clients and an
// 8-cycle hold watchdog.
module tb_mutex_grant_server;

    localparam logic [1:0] S_I = 2'b00;
    localparam logic [1:0] S_T = 2'b01;
    localparam logic [1:0] S_C = 2'b10;
    localparam logic [1:0] S_E = 2'b11;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] rel;
    logic [7:0] state;
    logic [3:0] grant;
    logic       x;
    logic [1:0] owner;
    logic       owner_valid;
    logic       timeout_pulse;
    logic       proto_err;

    int tests_run;
    int tests_failed;
    int cyc;

    mutex_grant_server #(
        .NCLIENT (4),
        .HOLD_MAX(8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .rel          (rel),
        .state        (state),
        .grant        (grant),
        .x            (x),
        .owner        (owner),
        .owner_valid  (owner_valid),
        .timeout_pulse(timeout_pulse),
        .proto_err    (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] st(input int i);
        return state[2*i +: 2];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        req   = '0;
        rel   = '0;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        req   = '0;
        rel   = '0;
        reset = 1'b1;
        step();
        tests_run++;
        if (state !== 8'h00 || grant !== 4'b0000 || x !== 1'b1 || owner_valid !== 1'b0
            || owner !== 2'd0 || proto_err !== 1'b0 || timeout_pulse !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: state=%h grant=%b x=%b ov=%b owner=%0d perr=%b to=%b expected 00 0000 1 0 0 0 0",
                     state, grant, x, owner_valid, owner, proto_err, timeout_pulse);
        end
        reset = 1'b0;
        step();
        tests_run++;
        if (state !== 8'h00 || x !== 1'b1 || grant !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_idle: state=%h x=%b grant=%b expected 00 1 0000", state, x, grant);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001;
        step();
        req = '0;
        tests_run++;
        if (st(0) !== S_T || grant !== 4'b0000) begin
            tests_failed++;
            $display("FAIL single_try: st0=%b grant=%b expected 01 0000", st(0), grant);
        end
        step();
        tests_run++;
        if (st(0) !== S_C || grant !== 4'b0001 || x !== 1'b0 || owner !== 2'd0 || owner_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_grant: st0=%b grant=%b x=%b owner=%0d ov=%b expected 10 0001 0 0 1",
                     st(0), grant, x, owner, owner_valid);
        end
        step();
        rel = 4'b0001;
        step();
        rel = '0;
        tests_run++;
        if (st(0) !== S_E || grant !== 4'b0000 || x !== 1'b0 || owner_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_exit: st0=%b grant=%b x=%b ov=%b expected 11 0000 0 1",
                     st(0), grant, x, owner_valid);
        end
        step();
        tests_run++;
        if (st(0) !== S_I || x !== 1'b1 || owner_valid !== 1'b0 || proto_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_idle: st0=%b x=%b ov=%b perr=%b expected 00 1 0 0",
                     st(0), x, owner_valid, proto_err);
        end
    endtask

    task automatic test_round_robin();
        int         last_e;
        int         bad_onehot;
        int         waited;
        logic [3:0] exp_g;
        do_reset();
        last_e     = 0;
        bad_onehot = 0;
        req        = 4'b1111;
        for (int g = 0; g < 4; g++) begin
            exp_g  = 4'(1 << g);
            waited = 0;
            while (grant == 4'b0000 && waited < 10) begin
                step();
                waited++;
                if (!$onehot0(grant)) bad_onehot++;
            end
            tests_run++;
            if (grant !== exp_g) begin
                tests_failed++;
                $display("FAIL rr_order[%0d]: grant=%b expected %b", g, grant, exp_g);
            end
            if (g > 0) begin
                tests_run++;
                if (cyc - last_e != 2) begin
                    tests_failed++;
                    $display("FAIL rr_gap[%0d]: grant %0d cycles after E, expected 2", g, cyc - last_e);
                end
            end
            step();
            if (!$onehot0(grant)) bad_onehot++;
            rel = exp_g;
            step();
            rel    = '0;
            last_e = cyc;
            tests_run++;
            if (st(g) !== S_E) begin
                tests_failed++;
                $display("FAIL rr_exit[%0d]: st=%b expected 11", g, st(g));
            end
        end
        req = '0;
        tests_run++;
        if (bad_onehot != 0) begin
            tests_failed++;
            $display("FAIL rr_onehot: %0d cycles with multiple grants, expected 0", bad_onehot);
        end
    endtask

    task automatic test_watchdog();
        int cnt;
        do_reset();
        req = 4'b0100;
        step();
        req = 4'b1000;
        step();
        req = '0;
        tests_run++;
        if (grant !== 4'b0100 || st(3) !== S_T) begin
            tests_failed++;
            $display("FAIL wd_grant: grant=%b st3=%b expected 0100 01", grant, st(3));
        end
        cnt = 1;
        step();
        while (st(2) == S_C && cnt < 20) begin
            cnt++;
            step();
        end
        tests_run++;
        if (cnt != 8 || st(2) !== S_E || timeout_pulse !== 1'b1) begin
            tests_failed++;
            $display("FAIL wd_expire: cycles_in_C=%0d st2=%b to=%b expected 8 11 1", cnt, st(2), timeout_pulse);
        end
        step();
        tests_run++;
        if (timeout_pulse !== 1'b0 || st(2) !== S_I || x !== 1'b1 || grant !== 4'b0000 || st(3) !== S_T) begin
            tests_failed++;
            $display("FAIL wd_release: to=%b st2=%b x=%b grant=%b st3=%b expected 0 00 1 0000 01",
                     timeout_pulse, st(2), x, grant, st(3));
        end
        step();
        tests_run++;
        if (grant !== 4'b1000 || owner !== 2'd3) begin
            tests_failed++;
            $display("FAIL wd_next_grant: grant=%b owner=%0d expected 1000 3", grant, owner);
        end
    endtask

    task automatic test_proto_err();
        do_reset();
        rel = 4'b0010;
        step();
        rel = '0;
        tests_run++;
        if (proto_err !== 1'b1 || st(1) !== S_I) begin
            tests_failed++;
            $display("FAIL perr_set: perr=%b st1=%b expected 1 00", proto_err, st(1));
        end
        req = 4'b0001;
        step();
        req = '0;
        repeat (3) step();
        tests_run++;
        if (proto_err !== 1'b1 || st(0) !== S_C || st(1) !== S_I) begin
            tests_failed++;
            $display("FAIL perr_sticky: perr=%b st0=%b st1=%b expected 1 10 00", proto_err, st(0), st(1));
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        rel = 4'b0001;
        req = 4'b1000;
        step();
        rel = '0;
        req = '0;
        step();
        tests_run++;
        if (grant !== 4'b1000 || proto_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL areset_setup: grant=%b perr=%b expected 1000 1", grant, proto_err);
        end
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (state !== 8'h00 || x !== 1'b1 || grant !== 4'b0000 || proto_err !== 1'b0
            || timeout_pulse !== 1'b0 || owner_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL areset_immediate: state=%h x=%b grant=%b perr=%b to=%b ov=%b expected 00 1 0000 0 0 0",
                     state, x, grant, proto_err, timeout_pulse, owner_valid);
        end
        #1;
        reset = 1'b0;
        req   = 4'b1000;
        step();
        req = '0;
        tests_run++;
        if (st(3) !== S_T) begin
            tests_failed++;
            $display("FAIL areset_try: st3=%b expected 01", st(3));
        end
        step();
        tests_run++;
        if (grant !== 4'b1000 || x !== 1'b0) begin
            tests_failed++;
            $display("FAIL areset_regrant: grant=%b x=%b expected 1000 0", grant, x);
        end
    endtask

    task automatic test_rel_at_expiry();
        do_reset();
        req = 4'b0010;
        step();
        req = '0;
        step();
        repeat (7) step();
        tests_run++;
        if (st(1) !== S_C) begin
            tests_failed++;
            $display("FAIL expiry_hold: st1=%b expected 10", st(1));
        end
        rel = 4'b0010;
        step();
        rel = '0;
        tests_run++;
        if (st(1) !== S_E || timeout_pulse !== 1'b0 || proto_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL expiry_rel: st1=%b to=%b perr=%b expected 11 0 0", st(1), timeout_pulse, proto_err);
        end
        step();
        tests_run++;
        if (st(1) !== S_I || x !== 1'b1 || timeout_pulse !== 1'b0) begin
            tests_failed++;
            $display("FAIL expiry_idle: st1=%b x=%b to=%b expected 00 1 0", st(1), x, timeout_pulse);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        reset        = 1'b1;
        req          = '0;
        rel          = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_watchdog();
        test_proto_err();
        test_async_reset();
        test_rel_at_expiry();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mutex_grant_server.md
Name: mutex_grant_server

Overview:
- Responder side of the I/T/C/E mutual-exclusion protocol. Holds the shared semaphore x and per-client state, and grants exclusive critical-section access.
- Clients issue try (req) and exit (rel) pulses or levels. The server sequences each client I->T->C->E->I and admits at most one client to C.
- Grants are round-robin among clients in T. An optional hold watchdog revokes overlong tenure.
- Sits between the client rule engines and the shared-resource mux.

Parameters:
- NCLIENT, 4, number of clients (2..16).
- HOLD_MAX, 0, maximum cycles a client may stay in C; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req  in  NCLIENT  try request per client; level or pulse; sampled only while that client is in I
- rel  in  NCLIENT  exit request per client; sampled only while that client is in C
- state  out  2*NCLIENT  registered per-client state; client i occupies bits [2i+1:2i]; encoding I=00, T=01, C=10, E=11
- grant  out  NCLIENT  one-hot; bit i = (state_i==C); all-zero when no client is in C
- x  out  1  semaphore; 1 = free
- owner  out  max(1,$clog2(NCLIENT))  index of the client in C or E; 0 when owner_valid=0
- owner_valid  out  1  1 while any client is in C or E
- timeout_pulse  out  1  one-cycle pulse when the watchdog forces C->E
- proto_err  out  1  sticky; set on rel while the client is not in C

Behaviour:
- Reset (async): all states I, x=1, rr_ptr=0, hold_cnt=0, proto_err=0, timeout_pulse=0. All outputs are registered or decoded from registers, so grant=0 and owner_valid=0 during reset.
- Per-client transitions, all at the clock edge:
  - I: req_i=1 -> T; otherwise stay in I.
  - T: x=1 and client i is the round-robin winner -> C, x<=0, hold_cnt<=0, rr_ptr<=(i+1) mod NCLIENT.
  - C: rel_i=1 -> E. Otherwise, if HOLD_MAX!=0 and hold_cnt==HOLD_MAX-1 -> E with timeout_pulse<=1. Otherwise hold_cnt++.
  - E: -> I unconditionally, x<=1.
- Round-robin winner: the first client in T found by scanning from rr_ptr upward with wrap. At most one winner per cycle.
- Latency:
  - req seen at edge k -> T after k.
  - If uncontended with x=1 -> C after k+1, and grant is visible that cycle.
  - rel at edge m -> E after m, I with x=1 after m+1.
  - The next grant lands no earlier than m+2. The server never grants in the cycle x returns to 1.
- Simultaneous events:
  - rel and watchdog expiry in the same cycle -> treated as a normal exit; no timeout_pulse.
  - req while in T, C or E -> ignored, not an error.
  - rel while in I, T or E -> proto_err<=1; state unchanged.
- Invariants, checked by assertions:
  - At most one client in {C,E}.
  - x==0 iff owner_valid==1.
  - grant is one-hot0.
- hold_cnt width: max(1,$clog2(HOLD_MAX+1)). Its value is ignored when HOLD_MAX=0.
- Reset mid-C revokes immediately with no timeout_pulse.

Decomposition:
- Shared package mutex_pkg:
  - mstate_t enum {ST_I=2'b00, ST_T=2'b01, ST_C=2'b10, ST_E=2'b11}.
  - Helper function for index width.
- One sub-module, mutex_rr_pick: combinational round-robin selector.
  - Inputs: cand[NCLIENT], ptr.
  - Outputs: win_valid, win_idx.
- The top level holds the state array, x, rr_ptr, hold_cnt and the error/timeout flags.

Test Plan (NCLIENT=4, HOLD_MAX=8):
1. After reset, pulse req[0] in cycle 1 -> state0=T in cycle 2; C in cycle 3 with grant=0001, x=0, owner=0. Pulse rel[0] in cycle 5 -> E in cycle 6; I in cycle 7 with x=1, owner_valid=0.
2. req=1111 held from cycle 1 -> grant order 0001, 0010, 0100, 1000 (each released after 2 cycles in C). Never two bits set. Each grant ≥2 cycles after the previous E.
3. Client 2 granted, never releases -> exactly 8 cycles in C, then E with timeout_pulse=1 for 1 cycle, then I, x=1. A pending client 3 is granted 2 cycles after E.
4. rel[1] while state1=I -> proto_err=1 and stays 1 through subsequent traffic until reset. state1 stays I.
5. Assert reset asynchronously while client 3 is in C -> state=0, x=1, grant=0000, proto_err=0 immediately. A new req[3] after deassert is granted with the case-1 latency.
6. Client 1 in C at hold_cnt=7 with rel[1]=1 in the same cycle -> E with timeout_pulse=0.
